cnt_dly_cfg_ctrl: RTL and testbench

- Configuration sequencer for a bank of N_CELLS SLG46620-style CNT/DLY macrocells.
- Accepts one configuration command at a time from a host over a valid/ready channel, and validates the encodings (clock source, edge/reset mode, function, wake-sleep state).
- Applies a valid command with a safe hold/load sequence on the target cell, then returns a status response.
- Sits between the host register interface and the CNT/DLY macrocell instances.

---
 rtl/cnt_dly_cfg_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cnt_dly_cfg_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_dly_cfg_ctrl.sv
// Configuration sequencer for a bank of CNT/DLY macrocells: validates a host
// command, then freezes, loads and releases the target cell before responding.
module cnt_dly_cfg_ctrl #(
  parameter int N_CELLS     = 4,
  parameter int CELL_W      = 2,
  parameter int DATA_W      = 14,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CELL_W-1:0]      cfg_cell,
  input  logic [3:0]             cfg_clk_sel,
  input  logic [1:0]             cfg_edge,
  input  logic [1:0]             cfg_func,
  input  logic                   cfg_ws,
  input  logic [DATA_W-1:0]      cfg_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_code,
  output logic                   busy,
  output logic [N_CELLS-1:0]     cell_hold,
  output logic [N_CELLS-1:0]     cell_load,
  output logic [4*N_CELLS-1:0]   cell_clk_sel,
  output logic [2*N_CELLS-1:0]   cell_edge,
  output logic [2*N_CELLS-1:0]   cell_func,
  output logic [N_CELLS-1:0]     cell_ws,
  output logic [DATA_W*N_CELLS-1:0] cell_data
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_HOLD,
    S_LOAD,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [1:0]          code_q, code_d;

  logic [CELL_W-1:0]   cmd_cell_q;
  logic [3:0]          cmd_clk_q;
  logic [1:0]          cmd_edge_q;
  logic [1:0]          cmd_func_q;
  logic                cmd_ws_q;
  logic [DATA_W-1:0]   cmd_data_q;

  logic                cfg_ready_q, rsp_valid_q, busy_q;
  logic [N_CELLS-1:0]  hold_q, load_q;
  logic [N_CELLS-1:0]  target_onehot;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    code_d     = code_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready_q) state_d = S_CHECK;
      end
      S_CHECK: begin
        // Error priority: bad cell, reserved clock, unsupported mode.
        if ({1'b0, cmd_cell_q} >= (CELL_W + 1)'(N_CELLS))        code_d = 2'b01;
        else if (cmd_clk_q >= 4'b1101)                            code_d = 2'b10;
        else if (cmd_func_q == 2'b11)                             code_d = 2'b11;
        else if (cmd_func_q == 2'b00 && cmd_edge_q == 2'b00)      code_d = 2'b11;
        else                                                      code_d = 2'b00;
        hold_cnt_d = '0;
        state_d    = (code_d == 2'b00) ? S_HOLD : S_RESP;
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = S_LOAD;
        else                         hold_cnt_d = hold_cnt_q + 1'b1;
      end
      S_LOAD: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      code_q      <= 2'b00;
      cfg_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      hold_q      <= '0;
      load_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      code_q      <= code_d;
      // Status outputs are registered from the next state so they line up with it.
      cfg_ready_q <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_RESP);
      busy_q      <= (state_d != S_IDLE);
      hold_q      <= (state_d == S_HOLD || state_d == S_LOAD) ? target_onehot : '0;
      load_q      <= (state_d == S_LOAD) ? target_onehot : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cell_q <= '0;
      cmd_clk_q  <= '0;
      cmd_edge_q <= '0;
      cmd_func_q <= '0;
      cmd_ws_q   <= 1'b0;
      cmd_data_q <= '0;
    end else if (state_q == S_IDLE && cfg_valid) begin
      cmd_cell_q <= cfg_cell;
      cmd_clk_q  <= cfg_clk_sel;
      cmd_edge_q <= cfg_edge;
      cmd_func_q <= cfg_func;
      cmd_ws_q   <= cfg_ws;
      cmd_data_q <= cfg_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CELLS; gi++) begin : g_cell
      logic [3:0]        clk_q;
      logic [1:0]        edge_q;
      logic [1:0]        func_q;
      logic              ws_q;
      logic [DATA_W-1:0] data_q;

      assign target_onehot[gi] = (cmd_cell_q == CELL_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          clk_q  <= 4'b0000;
          edge_q <= 2'b11;
          func_q <= 2'b00;
          ws_q   <= 1'b1;
          data_q <= '0;
        end else if (state_q == S_LOAD && target_onehot[gi]) begin
          clk_q  <= cmd_clk_q;
          edge_q <= cmd_edge_q;
          func_q <= cmd_func_q;
          ws_q   <= cmd_ws_q;
          data_q <= cmd_data_q;
        end
      end

      assign cell_clk_sel[4*gi +: 4]        = clk_q;
      assign cell_edge[2*gi +: 2]           = edge_q;
      assign cell_func[2*gi +: 2]           = func_q;
      assign cell_ws[gi]                    = ws_q;
      assign cell_data[DATA_W*gi +: DATA_W] = data_q;
    end
  endgenerate

  assign cfg_ready = cfg_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_code  = code_q;
  assign busy      = busy_q;
  assign cell_hold = hold_q;
  assign cell_load = load_q;

endmodule

// File: tb/tb_cnt_dly_cfg_ctrl.sv
// Directed self-checking bench for cnt_dly_cfg_ctrl with three cells so that
// index 3 exercises the bad-cell path.
module tb_cnt_dly_cfg_ctrl;
  localparam int N  = 3;
  localparam int CW = 2;
  localparam int DW = 14;
  localparam int HC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid, cfg_ready;
  logic [CW-1:0]   cfg_cell;
  logic [3:0]      cfg_clk_sel;
  logic [1:0]      cfg_edge, cfg_func;
  logic            cfg_ws;
  logic [DW-1:0]   cfg_data;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_code;
  logic            busy;
  logic [N-1:0]    cell_hold, cell_load, cell_ws;
  logic [4*N-1:0]  cell_clk_sel;
  logic [2*N-1:0]  cell_edge, cell_func;
  logic [DW*N-1:0] cell_data;

  int checks = 0;
  int failures = 0;

  // Expected active cell registers, maintained from hand-written constants.
  logic [4*N-1:0]  exp_clk;
  logic [2*N-1:0]  exp_edge, exp_func;
  logic [N-1:0]    exp_ws;
  logic [DW*N-1:0] exp_data;

  cnt_dly_cfg_ctrl #(.N_CELLS(N), .CELL_W(CW), .DATA_W(DW), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_cell(cfg_cell),
    .cfg_clk_sel(cfg_clk_sel), .cfg_edge(cfg_edge), .cfg_func(cfg_func),
    .cfg_ws(cfg_ws), .cfg_data(cfg_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code), .busy(busy),
    .cell_hold(cell_hold), .cell_load(cell_load), .cell_clk_sel(cell_clk_sel),
    .cell_edge(cell_edge), .cell_func(cell_func), .cell_ws(cell_ws), .cell_data(cell_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_reset();
    exp_clk  = '0;
    exp_edge = '1;
    exp_func = '0;
    exp_ws   = '1;
    exp_data = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_clk"},  64'(cell_clk_sel), 64'(exp_clk));
    check({tag, "_edge"}, 64'(cell_edge),    64'(exp_edge));
    check({tag, "_func"}, 64'(cell_func),    64'(exp_func));
    check({tag, "_ws"},   64'(cell_ws),      64'(exp_ws));
    check({tag, "_data"}, 64'(cell_data),    64'(exp_data));
  endtask

  // Presents one command in an IDLE cycle; returns in the CHECK cycle (T1).
  task automatic send(input logic [1:0] c, input logic [3:0] ck, input logic [1:0] e,
                      input logic [1:0] f, input logic w, input logic [13:0] d);
    cfg_cell = c; cfg_clk_sel = ck; cfg_edge = e; cfg_func = f; cfg_ws = w; cfg_data = d;
    check("accept_ready", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic err_case(input string tag, input logic [1:0] c, input logic [3:0] ck,
                          input logic [1:0] e, input logic [1:0] f, input logic [1:0] code);
    send(c, ck, e, f, 1'b0, 14'h2AAA);
    check({tag, "_t1_hold"}, 64'(cell_hold), 64'd0);
    check({tag, "_t1_rsp"},  64'(rsp_valid), 64'd0);
    tick();
    check({tag, "_t2_rsp"},  64'(rsp_valid), 64'd1);
    check({tag, "_code"},    64'(rsp_code),  64'(code));
    check({tag, "_hold"},    64'(cell_hold), 64'd0);
    check({tag, "_load"},    64'(cell_load), 64'd0);
    check_regs(tag);
    tick();
    check({tag, "_idle"},    64'(cfg_ready), 64'd1);
    $display("err %s code=%0d", tag, rsp_code);
  endtask

  // From T1, runs until rsp_valid (bounded) counting hold and load cycles.
  task automatic run_ok(input string tag, input int exp_holds);
    int holds = 0;
    int loads = 0;
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rsp_valid) done = 1;
      else begin
        if (cell_hold != '0) holds++;
        if (cell_load != '0) loads++;
        tick();
      end
    end
    check({tag, "_timeout"}, 64'(done), 64'd1);
    check({tag, "_holds"},   64'(holds), 64'(exp_holds));
    check({tag, "_loads"},   64'(loads), 64'd1);
    check({tag, "_code"},    64'(rsp_code), 64'd0);
    check_regs(tag);
    $display("ok %s holds=%0d loads=%0d", tag, holds, loads);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; rsp_ready = 1'b1;
    cfg_cell = '0; cfg_clk_sel = '0; cfg_edge = '0; cfg_func = '0; cfg_ws = 1'b0; cfg_data = '0;
    exp_reset();
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_ready", 64'(cfg_ready), 64'd1);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_rsp",   64'(rsp_valid), 64'd0);
    check("rst_code",  64'(rsp_code),  64'd0);
    check("rst_hold",  64'(cell_hold), 64'd0);
    check("rst_load",  64'(cell_load), 64'd0);
    check_regs("rst");
    $display("reset checked");

    // Cell 2: clk 0100, edge 10, func 01 (CNT), ws 1, data 0x1234.
    send(2'd2, 4'b0100, 2'b10, 2'b01, 1'b1, 14'h1234);
    check("t1_busy",  64'(busy),      64'd1);
    check("t1_ready", 64'(cfg_ready), 64'd0);
    check("t1_hold",  64'(cell_hold), 64'd0);
    tick();
    check("t2_hold",  64'(cell_hold), 64'b100);
    check("t2_load",  64'(cell_load), 64'b000);
    tick();
    check("t3_hold",  64'(cell_hold), 64'b100);
    check("t3_load",  64'(cell_load), 64'b000);
    check_regs("t3");
    tick();
    check("t4_hold",  64'(cell_hold), 64'b100);
    check("t4_load",  64'(cell_load), 64'b100);
    check("t4_rsp",   64'(rsp_valid), 64'd0);
    tick();
    exp_clk  = 12'h400;
    exp_edge = 6'b10_11_11;
    exp_func = 6'b01_00_00;
    exp_data = {14'h1234, 14'h0000, 14'h0000};
    check("t5_rsp",   64'(rsp_valid), 64'd1);
    check("t5_code",  64'(rsp_code),  64'd0);
    check("t5_hold",  64'(cell_hold), 64'd0);
    check("t5_load",  64'(cell_load), 64'd0);
    check_regs("t5");
    tick();
    check("t6_ready", 64'(cfg_ready), 64'd1);
    check("t6_rsp",   64'(rsp_valid), 64'd0);
    $display("cell2 load done");

    err_case("badcell",  2'd3, 4'b0000, 2'b01, 2'b01, 2'b01);
    err_case("clk1110",  2'd0, 4'b1110, 2'b01, 2'b01, 2'b10);
    err_case("clk1101",  2'd1, 4'b1101, 2'b01, 2'b00, 2'b10);
    err_case("func11",   2'd1, 4'b0010, 2'b01, 2'b11, 2'b11);
    err_case("dlyboth",  2'd0, 4'b0010, 2'b00, 2'b00, 2'b11);
    err_case("prio",     2'd3, 4'b1111, 2'b00, 2'b11, 2'b01);

    // Backpressure on cell 1 (clk 1100 is the highest legal select).
    rsp_ready = 1'b0;
    send(2'd1, 4'b1100, 2'b01, 2'b10, 1'b0, 14'h0ABC);
    tick(); tick(); tick(); tick();
    exp_clk[7:4]    = 4'b1100;
    exp_edge[3:2]   = 2'b01;
    exp_func[3:2]   = 2'b10;
    exp_ws[1]       = 1'b0;
    exp_data[27:14] = 14'h0ABC;
    cfg_cell = 2'd0; cfg_clk_sel = 4'b0001; cfg_edge = 2'b01; cfg_func = 2'b11; cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp",   64'(rsp_valid), 64'd1);
      check("bp_code",  64'(rsp_code),  64'd0);
      check("bp_ready", 64'(cfg_ready), 64'd0);
      tick();
    end
    check_regs("bp");
    rsp_ready = 1'b1;
    check("bp_last_rsp", 64'(rsp_valid), 64'd1);
    tick();
    check("bp_idle_ready", 64'(cfg_ready), 64'd1);
    check("bp_idle_busy",  64'(busy),      64'd0);
    check("bp_idle_rsp",   64'(rsp_valid), 64'd0);
    tick();
    cfg_valid = 1'b0;
    check("bp_next_busy",  64'(busy),      64'd1);
    tick();
    check("bp_next_rsp",   64'(rsp_valid), 64'd1);
    check("bp_next_code",  64'(rsp_code),  64'd3);
    tick();
    $display("backpressure done");

    // Reset in HOLD drops the command and restores defaults everywhere.
    send(2'd0, 4'b0011, 2'b01, 2'b01, 1'b0, 14'h1111);
    tick();
    check("rh_hold_pre", 64'(cell_hold), 64'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_reset();
    check("rh_hold",  64'(cell_hold), 64'd0);
    check("rh_rsp",   64'(rsp_valid), 64'd0);
    check("rh_ready", 64'(cfg_ready), 64'd1);
    check_regs("rh");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rh_quiet", 64'(rsp_valid | busy | (|cell_hold) | (|cell_load)), 64'd0);
    end
    $display("reset in hold done");

    // Back-to-back to cell 0.
    send(2'd0, 4'b0011, 2'b01, 2'b01, 1'b1, 14'h0AAA);
    exp_clk[3:0] = 4'b0011; exp_edge[1:0] = 2'b01; exp_func[1:0] = 2'b01; exp_data[13:0] = 14'h0AAA;
    run_ok("b2b_a", HC + 1);
    tick();
    send(2'd0, 4'b0101, 2'b10, 2'b10, 1'b0, 14'h3FFF);
    exp_clk[3:0] = 4'b0101; exp_edge[1:0] = 2'b10; exp_func[1:0] = 2'b10;
    exp_ws[0] = 1'b0; exp_data[13:0] = 14'h3FFF;
    run_ok("b2b_b", HC + 1);
    tick();
    check("end_ready", 64'(cfg_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
